// File: rtl/cbp_serial_adder_pkg.sv
// Shared constants and FSM state type for the nibble-serial 32-bit adder.
package cbp_pkg;

  localparam int WORD_W  = 32;
  localparam int NIB_W   = 4;
  localparam int NIB_CNT = 8;
  localparam int CNT_W   = $clog2(NIB_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cbp_serial_adder_if.sv
// Request/response bundle of the serial adder: operand request handshake,
// result handshake and status.
interface cbp_serial_adder_if;
  import cbp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] sum;
  logic              cout;
  logic              overflow;
  logic              busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );

endinterface

// File: rtl/cbp_serial_adder_slice.sv
// 4-bit carry-bypass adder slice, purely combinational. When every bit
// propagates, the carry-in is forwarded straight to the carry-out.
module cbp_nibble_slice
  import cbp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  // Ripple chain plus bypass mux on the group carry-out.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s  = p ^ c[NIB_W-1:0];
    co = (&p) ? ci : c[NIB_W];
  end

endmodule

// File: rtl/cbp_serial_adder.sv
// Nibble-serial 32-bit adder: one shared carry-bypass slice, LSB nibble
// first, result presented 8 cycles after the request is accepted.
// Optional feature macro: CBP_SERIAL_OVERFLOW_EN (signed overflow flag;
// when undefined the overflow port is tied low).
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand request
// RUN   | one nibble per cycle through the slice, cnt selects the nibble
// DONE  | out_valid=1, result held until out_ready
module cbp_serial_adder
  import cbp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cbp_serial_adder_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic [WORD_W-1:0] work_q, work_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [4:0]        bit_lo;
  logic [NIB_W-1:0]  slice_a;
  logic [NIB_W-1:0]  slice_b;
  logic [NIB_W-1:0]  slice_s;
  logic              slice_co;

  assign bit_lo  = {cnt_q, 2'b00};
  assign slice_a = a_q[bit_lo +: NIB_W];
  assign slice_b = b_q[bit_lo +: NIB_W];

  cbp_nibble_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Next-state, operand capture, nibble accumulation and result publication.
  // The visible sum/cout only change on the final nibble, so they hold their
  // last values outside DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[bit_lo +: NIB_W] = slice_s;
        carry_d                 = slice_co;
        if (cnt_q == CNT_W'(NIB_CNT - 1)) begin
          sum_d   = {slice_s, work_q[WORD_W-NIB_W-1:0]};
          cout_d  = slice_co;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef CBP_SERIAL_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Signed overflow from latched operand signs and the final sum sign bit.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && cnt_q == CNT_W'(NIB_CNT - 1)) begin
      ovf_d = (a_q[WORD_W-1] == b_q[WORD_W-1]) & (slice_s[NIB_W-1] != a_q[WORD_W-1]);
    end
  end

  // Overflow flag register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cbp_serial_adder.sv
// Directed and random checks of the nibble-serial adder against a plain
// arithmetic reference.
module tb_cbp_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cbp_serial_adder_if bus ();

  cbp_serial_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed overflow from the true signed total.
  task automatic ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output logic [31:0] s, output logic co, output logic ov);
    logic [32:0] full;
    longint      st;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    s    = full[31:0];
    co   = full[32];
    st   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
`ifdef CBP_SERIAL_OVERFLOW_EN
    ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
`else
    ov = 1'b0;
`endif
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int hold, input bit noise, input string tag);
    logic [31:0] es;
    logic        ec, eo;
    int          cyc;
    ref_add(a, b, cin, es, ec, eo);
    @(negedge clk);
    chk({tag, ".idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (noise) begin
      bus.a   = $urandom;
      bus.b   = $urandom;
      bus.cin = 1'($urandom_range(0, 1));
    end else begin
      bus.in_valid = 1'b0;
    end
    chk({tag, ".run_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, ".run_busy"}, {31'd0, bus.busy}, 32'd1);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, 32'd8);
    chk({tag, ".sum"}, bus.sum, es);
    chk({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".hold_sum"}, bus.sum, es);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".ret_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, ".ret_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".ret_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".ret_sum"}, bus.sum, es);
  endtask

  initial begin
    bit seen;
    logic [31:0] ovf_exp;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.sum", bus.sum, 32'd0);
    chk("rst.cout", {31'd0, bus.cout}, 32'd0);
    chk("rst.ovf", {31'd0, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 0, 1'b0, "prop");
    chk("prop.sum_const", bus.sum, 32'h00000000);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1, 1'b0, "mixed");
    chk("mixed.sum_const", bus.sum, 32'hACF13568);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, "sovf");
`ifdef CBP_SERIAL_OVERFLOW_EN
    ovf_exp = 32'd1;
`else
    ovf_exp = 32'd0;
`endif
    chk("sovf.sum_const", bus.sum, 32'h80000000);
    chk("sovf.ovf_const", {31'd0, bus.overflow}, ovf_exp);
    run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 5, 1'b1, "bp");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 1'b0, "allprop");
    run_op(32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, "negovf");

    // Abort at cnt==3: the result must never appear.
    @(negedge clk);
    bus.a        = 32'h55555555;
    bus.b        = 32'h33333333;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort.busy", {31'd0, bus.busy}, 32'd0);
    chk("abort.sum", bus.sum, 32'd0);
    chk("abort.cout", {31'd0, bus.cout}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen |= bus.out_valid;
    end
    chk("abort.no_result", {31'd0, seen}, 32'd0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, "post");
    chk("post.sum_const", bus.sum, 32'd0);
    chk("post.cout_const", {31'd0, bus.cout}, 32'd1);

    for (int k = 0; k < 24; k++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cbp_serial_adder.md
CBP_SERIAL_ADDER -- requirements
Module: cbp_serial_adder

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
  clk  input  1  sole clock; all state updates on rising edge.
  rst  input  1  synchronous active-high reset.
  in_valid  input  1  operand request valid.
  in_ready  output  1  block can accept an operand request.
  a  input  32  operand A.
  b  input  32  operand B.
  cin  input  1  carry-in.
  out_valid  output  1  result valid.
  out_ready  input  1  consumer accepts result.
  sum  output  32  a+b+cin, mod 2^32.
  cout  output  1  carry out of bit 31.
  overflow  output  1  signed overflow flag.
  busy  output  1  high in RUN or DONE.
REQ-002 The block SHALL have one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL compute the 32-bit sum with one shared 4-bit carry-bypass slice, processing one nibble per cycle, LSB nibble first.
REQ-004 The FSM SHALL have three states:
  IDLE: in_ready=1.
  RUN: computing.
  DONE: out_valid=1.
REQ-005 in_ready SHALL be 1 only in IDLE; there SHALL be no overlap of requests.
REQ-006 On an edge with in_valid&&in_ready, the block SHALL latch a, b and cin, set the 3-bit nibble counter to 0, and enter RUN.
REQ-007 In RUN, at each edge: slice inputs = nibble[cnt] of latched a/b plus carry register; the sum nibble SHALL be written to result[4*cnt+3:4*cnt]; the carry register SHALL take the slice carry-out; cnt increments.
REQ-008 Slice carry-out SHALL equal carry-in when all four propagate bits (a^b) are 1, else the ripple carry.
REQ-009 At the edge where cnt==7, the block SHALL enter DONE.
REQ-010 out_valid SHALL be first high exactly 8 cycles after the accept edge.
REQ-011 In DONE, sum, cout and overflow SHALL be held stable until out_valid&&out_ready is sampled; that edge SHALL return the FSM to IDLE.
REQ-012 in_valid asserted during RUN/DONE SHALL be ignored, and the latched operands SHALL NOT change.
REQ-013 cout SHALL be the final carry register value.
REQ-014 sum, cout and overflow SHALL be meaningful only while out_valid=1, and SHALL retain their last values otherwise.
REQ-015 Counter wrap from 7 to 0 SHALL never occur in RUN; cnt SHALL be 0 in IDLE.

Reset
REQ-016 When rst=1 at an edge, the block SHALL enter IDLE with cnt=0, carry=0, sum=0, cout=0, overflow=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-017 rst asserted in RUN or DONE SHALL abort the operation, and no result SHALL be presented.
REQ-018 rst SHALL take priority over a simultaneous in_valid or out_ready handshake.

Configuration
REQ-019 With macro CBP_SERIAL_OVERFLOW_EN defined, overflow SHALL equal (a[31]==b[31]) & (sum[31]!=a[31]) using the latched operands.
REQ-020 Without CBP_SERIAL_OVERFLOW_EN, the overflow port SHALL remain present and be tied to 0, and no overflow logic SHALL be synthesized.

Structure
REQ-021 A shared package cbp_pkg SHALL hold:
  WORD_W=32, NIB_W=4, NIB_CNT=8.
  the FSM state enum (IDLE, RUN, DONE).
REQ-022 The 4-bit slice SHALL be a sub-module named cbp_nibble_slice with inputs a[3:0], b[3:0], ci and outputs s[3:0], co; it SHALL be purely combinational.
REQ-023 The top level SHALL contain only the FSM, counter, operand/result/carry registers and the overflow logic.

Verification
REQ-024 Propagate-all case: a=0x0F0F0F0F, b=0xF0F0F0F0, cin=1 -> sum=0x00000000, cout=1, overflow=0, out_valid on cycle 8 after accept.
REQ-025 Mixed-carry case: a=0x12345678, b=0x9ABCDEF0, cin=0 -> sum=0xACF13568, cout=0, overflow=0.
REQ-026 Signed overflow, macro defined: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1. Macro undefined: overflow=0.
REQ-027 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and sum stable throughout; a new in_valid during this time is ignored; the FSM returns to IDLE on the first out_ready=1 edge.
REQ-028 Reset mid-RUN at cnt=3 -> next cycle IDLE, out_valid=0, in_ready=1, sum=0. A following request a=0xFFFFFFFF, b=0x00000001 -> sum=0, cout=1.
